// File: rtl/wfunc_apb_loader.sv
// APB requester that soft-resets the window-function completer, streams a full
// window of coefficients into it, arms it and polls its status until ready.
module wfunc_apb_loader #(
  parameter int FFT_SIZE = 8192,
  parameter int APB_AW   = $clog2(FFT_SIZE-1)+3,
  parameter int POLL_MAX = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              coef_tvalid,
  output logic              coef_tready,
  input  logic [31:0]       coef_tdata,
  input  logic              coef_tlast,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [APB_AW-1:0] paddr,
  output logic [31:0]       pwdata,
  input  logic [31:0]       prdata,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int CW = $clog2(FFT_SIZE);
  localparam int PW = $clog2(POLL_MAX+1);
  localparam logic [APB_AW-1:0] CTRL_ADDR = APB_AW'(FFT_SIZE*4);
  localparam logic [APB_AW-1:0] STAT_ADDR = APB_AW'((FFT_SIZE+1)*4);
  localparam logic [CW-1:0]     LAST_BEAT = CW'(FFT_SIZE-1);

  typedef enum logic [2:0] {IDLE, RST, LOAD_WAIT, LOAD_WR, ARM, POLL, FINISH} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [PW-1:0] poll_cnt;
  logic          last_r;

  logic unused_prdata;
  assign unused_prdata = ^{prdata[31:10], prdata[7:0]};

  // Every transfer is SETUP then ACCESS; penable low marks the SETUP cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      coef_tready <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      cnt         <= '0;
      poll_cnt    <= '0;
      last_r      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state  <= RST;
          busy   <= 1'b1;
          err    <= 1'b0;
          psel   <= 1'b1;
          pwrite <= 1'b1;
          paddr  <= CTRL_ADDR;
          pwdata <= 32'h0000_0001;
        end
        RST: if (!penable) penable <= 1'b1;
        else begin
          psel        <= 1'b0;
          penable     <= 1'b0;
          cnt         <= '0;
          coef_tready <= 1'b1;
          state       <= LOAD_WAIT;
        end
        LOAD_WAIT: if (coef_tvalid) begin
          coef_tready <= 1'b0;
          last_r      <= coef_tlast;
          pwdata      <= coef_tdata;
          paddr       <= APB_AW'({cnt, 2'b00});
          pwrite      <= 1'b1;
          psel        <= 1'b1;
          state       <= LOAD_WR;
        end
        LOAD_WR: if (!penable) penable <= 1'b1;
        else begin
          penable <= 1'b0;
          if (cnt == LAST_BEAT && last_r) begin
            // ARM write follows back-to-back, psel stays high
            paddr  <= CTRL_ADDR;
            pwdata <= 32'h0000_0100;
            state  <= ARM;
          end else if (cnt != LAST_BEAT && !last_r) begin
            psel        <= 1'b0;
            cnt         <= cnt + CW'(1);
            coef_tready <= 1'b1;
            state       <= LOAD_WAIT;
          end else begin
            psel  <= 1'b0;
            err   <= 1'b1;
            done  <= 1'b1;
            state <= FINISH;
          end
        end
        ARM: if (!penable) penable <= 1'b1;
        else begin
          penable  <= 1'b0;
          pwrite   <= 1'b0;
          paddr    <= STAT_ADDR;
          poll_cnt <= '0;
          state    <= POLL;
        end
        POLL: if (!penable) penable <= 1'b1;
        else begin
          penable <= 1'b0;
          if (prdata[9:8] == 2'b01) begin
            psel  <= 1'b0;
            done  <= 1'b1;
            state <= FINISH;
          end else if (poll_cnt == PW'(POLL_MAX-1)) begin
            poll_cnt <= poll_cnt + PW'(1);
            psel     <= 1'b0;
            err      <= 1'b1;
            done     <= 1'b1;
            state    <= FINISH;
          end else begin
            poll_cnt <= poll_cnt + PW'(1);
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wfunc_apb_loader.sv
// Directed bench: expected APB transfers queued per sequence, a monitor pops
// and checks each ACCESS cycle and the SETUP/ACCESS pairing.
module tb_wfunc_apb_loader;
  localparam int FFT = 8;
  localparam int PM  = 4;
  localparam int AW  = 6;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } txn_t;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic          coef_tvalid = 1'b0, coef_tlast = 1'b0;
  logic [31:0]   coef_tdata = '0;
  logic          coef_tready, psel, penable, pwrite, busy, done, err;
  logic [AW-1:0] paddr;
  logic [31:0]   pwdata, prdata;

  int checks = 0, failures = 0;
  int rd_cnt = 0, rd_base = 0, stat_ok_at = 1;
  txn_t exp_q[$];

  wfunc_apb_loader #(.FFT_SIZE(FFT), .POLL_MAX(PM)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .coef_tvalid(coef_tvalid), .coef_tready(coef_tready),
    .coef_tdata(coef_tdata), .coef_tlast(coef_tlast),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Status completer: returns ready on the stat_ok_at-th read of a sequence (0 = never).
  assign prdata = (stat_ok_at != 0 && (rd_cnt - rd_base + 1) >= stat_ok_at) ? 32'h100 : 32'h0;
  always @(posedge clk) if (psel && penable && !pwrite) rd_cnt <= rd_cnt + 1;

  // Monitor
  initial begin
    logic          prev_setup;
    logic          p_wr;
    logic [AW-1:0] p_addr;
    logic [31:0]   p_data;
    txn_t          e;
    prev_setup = 1'b0; p_wr = 1'b0; p_addr = '0; p_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) prev_setup = 1'b0;
      else begin
        if (prev_setup) begin
          checks++;
          if (!(psel && penable && paddr == p_addr && pwrite == p_wr && pwdata == p_data)) begin
            failures++;
            $display("FAIL apb_access actual psel=%0b pen=%0b addr=%0h data=%0h required ACCESS addr=%0h data=%0h",
                     psel, penable, paddr, pwdata, p_addr, p_data);
          end
        end else if (penable) begin
          checks++; failures++;
          $display("FAIL apb_setup actual penable=1 without SETUP required SETUP first");
        end
        if (psel && penable) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL apb_txn actual wr=%0b addr=%0h data=%0h required none", pwrite, paddr, pwdata);
          end else begin
            e = exp_q.pop_front();
            if (e.wr !== pwrite || e.addr !== paddr || (e.wr && e.data !== pwdata)) begin
              failures++;
              $display("FAIL apb_txn actual wr=%0b addr=%0h data=%0h required wr=%0b addr=%0h data=%0h",
                       pwrite, paddr, pwdata, e.wr, e.addr, e.data);
            end
          end
        end
        prev_setup = psel && !penable;
        p_wr = pwrite; p_addr = paddr; p_data = pwdata;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] beat_data(input int i);
    return {16'(i + 1), 16'(i)};
  endfunction

  task automatic push_seq(input int n, input bit arm, input int reads);
    exp_q.push_back('{1'b1, 6'h20, 32'h1});
    for (int i = 0; i < n; i++) exp_q.push_back('{1'b1, AW'(i * 4), beat_data(i)});
    if (arm) exp_q.push_back('{1'b1, 6'h20, 32'h100});
    for (int i = 0; i < reads; i++) exp_q.push_back('{1'b0, 6'h24, 32'h0});
  endtask

  // Called at a negedge; returns at a negedge. Bails out if reset is asserted.
  task automatic send(input int n, input int last_at, input bit toggle);
    for (int i = 0; i < n; i++) begin
      int t;
      coef_tvalid = 1'b1; coef_tdata = beat_data(i); coef_tlast = (i == last_at);
      t = 0;
      while (!coef_tready && rst_n && t < 300) begin @(negedge clk); t++; end
      if (!rst_n) begin coef_tvalid = 1'b0; return; end
      if (t >= 300) begin
        chk("tready_timeout", 64'(i), 64'hFFFF);
        coef_tvalid = 1'b0; return;
      end
      @(negedge clk);
      coef_tvalid = 1'b0; coef_tlast = 1'b0;
      if (toggle) @(negedge clk);
    end
  endtask

  task automatic wait_done(input string name, input bit exp_err);
    int t;
    t = 0;
    while (!done && t < 400) begin @(negedge clk); t++; end
    chk({name, "_done_seen"}, 64'(done), 64'd1);
    chk({name, "_err"}, 64'(err), 64'(exp_err));
    @(negedge clk);
    chk({name, "_done_pulse_busy"}, {done, busy}, 2'b00);
    chk({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic run(input string name, input int n, input int last_at, input int stat,
                     input bit toggle, input bit mid_start, input bit exp_err,
                     input int reads, input bit arm);
    stat_ok_at = stat;
    rd_base = rd_cnt;
    push_seq(n, arm, reads);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk({name, "_busy_err_after_start"}, {busy, err}, 2'b10);
    fork
      send(n, last_at, toggle);
      if (mid_start) begin
        repeat (12) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    wait_done(name, exp_err);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", {psel, penable, pwrite, paddr, pwdata, coef_tready, busy, done, err}, '0);
    rst_n = 1'b1;
    run("nominal",   8, 7,  1, 1'b0, 1'b0, 1'b0, 1, 1'b1);
    run("early_last", 4, 3, 1, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    repeat (3) @(negedge clk);
    chk("err_sticky_idle", {err, busy}, 2'b10);
    run("no_last",   8, -1, 1, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    run("stat_stuck", 8, 7, 0, 1'b0, 1'b0, 1'b1, 4, 1'b1);
    run("stat_third", 8, 7, 3, 1'b0, 1'b0, 1'b0, 3, 1'b1);
    run("toggle_start", 8, 7, 1, 1'b1, 1'b1, 1'b0, 1, 1'b1);

    // Reset during ACCESS of beat 5
    stat_ok_at = 1;
    push_seq(6, 1'b0, 0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    fork
      send(8, 7, 1'b0);
      begin
        bit hit;
        hit = 1'b0;
        for (int t = 0; t < 300 && !hit; t++) begin
          @(negedge clk);
          if (psel && penable && paddr == 6'h14) hit = 1'b1;
        end
        chk("beat5_access_seen", 64'(hit), 64'd1);
        #1 rst_n = 1'b0;
        #1 chk("mid_reset_outputs",
               {psel, penable, pwrite, paddr, pwdata, coef_tready, busy, done, err}, '0);
      end
    join
    coef_tvalid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_reset_queue", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    rst_n = 1'b1;
    run("after_reset", 8, 7, 1, 1'b0, 1'b0, 1'b0, 1, 1'b1);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
